// File: rtl/imm_feeder.sv
// Raster-scan feeder: reads a ROWS x COLS frame from a sync-read source buffer and presents each pixel with its (i,j) index to the masking stage.
// Latency: 4 cycles per pixel (FETCH, CAPTURE, STROBE, ADVANCE) plus one FINISH cycle per frame.
// Backpressure: parks in CAPTURE with the pixel registered while out_ready is low; abort returns to IDLE at once.
module imm_feeder #(
    parameter int ROWS = 5,
    parameter int COLS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        out_ready,
    input  logic [11:0] mem_rdata,
    output logic        mem_rd_en,
    output logic [16:0] mem_addr,
    output logic [11:0] pixel,
    output logic [8:0]  i_p,
    output logic [7:0]  j_p,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        STROBE,
        ADVANCE,
        FINISH
    } state_t;

    localparam logic [8:0]  I_LAST = 9'(ROWS - 1);
    localparam logic [7:0]  J_LAST = 8'(COLS - 1);
    localparam logic [16:0] COLS_W = 17'(COLS);

    state_t      state, state_nxt;
    logic [8:0]  i, i_nxt;
    logic [7:0]  j, j_nxt;
    logic        cap_first;
    logic        last_col, last_pix;
    logic [16:0] addr_nxt;

    always_comb begin
        last_col = (j == J_LAST);
        last_pix = last_col && (i == I_LAST);
        j_nxt    = last_col ? 8'd0 : j + 8'd1;
        i_nxt    = last_col ? i + 9'd1 : i;
        addr_nxt = 17'(i_nxt) * COLS_W + 17'(j_nxt);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: if (out_ready) state_nxt = STROBE;
            STROBE:  state_nxt = ADVANCE;
            ADVANCE: state_nxt = last_pix ? FINISH : FETCH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            cap_first <= 1'b0;
            mem_addr  <= '0;
            pixel     <= '0;
            i_p       <= '0;
            j_p       <= '0;
        end else begin
            state     <= state_nxt;
            cap_first <= (state == FETCH);
            if (state == IDLE && state_nxt == FETCH) begin
                i        <= '0;
                j        <= '0;
                mem_addr <= '0;
            end
            // The address only moves on the way into FETCH, so it holds through the rest of the pixel.
            if (state == ADVANCE) begin
                i <= i_nxt;
                j <= j_nxt;
                if (state_nxt == FETCH) begin
                    mem_addr <= addr_nxt;
                end
            end
            // Read data lands during the first CAPTURE cycle; later CAPTURE cycles must not reload.
            if (state == CAPTURE && cap_first) begin
                pixel <= mem_rdata;
                i_p   <= i;
                j_p   <= j;
            end
        end
    end

    assign mem_rd_en = (state == FETCH);
    assign tx        = (state == STROBE);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);

endmodule

// File: tb/tb_imm_feeder.sv
// Bench for imm_feeder: a 5x5 instance for the main scenarios and a 3x7 instance for non-default geometry.
module tb_imm_feeder;

    logic        clk, rst_n, start, start2, abort, out_ready;
    logic        mem_rd_en, tx, busy, done;
    logic [16:0] mem_addr;
    logic [11:0] pixel, mem_rdata;
    logic [8:0]  i_p;
    logic [7:0]  j_p;
    logic        mem_rd_en2, tx2, busy2, done2;
    logic [16:0] mem_addr2;
    logic [11:0] pixel2, mem_rdata2;
    logic [8:0]  i_p2;
    logic [7:0]  j_p2;

    typedef struct packed {
        logic [8:0]  i;
        logic [7:0]  j;
        logic [11:0] pix;
    } rec_t;

    typedef struct {
        int          cyc;
        logic        tx, busy, done, rd;
        logic [16:0] addr;
        logic        pchk;
        logic [11:0] pix;
        logic [8:0]  ip;
        logic [7:0]  jp;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   done1_cnt = 0;
    int   done2_cnt = 0;
    logic tx1_prev = 1'b0;
    logic tx2_prev = 1'b0;
    rec_t q1[$];
    rec_t q2[$];
    vec_t tbl[16];

    imm_feeder #(.ROWS(5), .COLS(5)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
        .mem_rdata(mem_rdata), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .pixel(pixel),
        .i_p(i_p), .j_p(j_p), .tx(tx), .busy(busy), .done(done)
    );

    imm_feeder #(.ROWS(3), .COLS(7)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort), .out_ready(out_ready),
        .mem_rdata(mem_rdata2), .mem_rd_en(mem_rd_en2), .mem_addr(mem_addr2), .pixel(pixel2),
        .i_p(i_p2), .j_p(j_p2), .tx(tx2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read source buffers whose contents equal the low address bits.
    initial begin
        mem_rdata  = '0;
        mem_rdata2 = '0;
    end
    always @(posedge clk) begin
        if (mem_rd_en)  mem_rdata  <= mem_addr[11:0];
        if (mem_rd_en2) mem_rdata2 <= mem_addr2[11:0];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (tx) begin
            chk("tx_back_to_back", int'(tx1_prev), 0);
            q1.push_back(rec_t'({i_p, j_p, pixel}));
        end
        if (tx2) begin
            chk("tx2_back_to_back", int'(tx2_prev), 0);
            q2.push_back(rec_t'({i_p2, j_p2, pixel2}));
        end
        tx1_prev = tx;
        tx2_prev = tx2;
        if (done)  done1_cnt++;
        if (done2) done2_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse(input bit second);
        if (second) start2 = 1'b1;
        else        start  = 1'b1;
        tick();
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Raster order: the k-th emitted pixel is (k/cols, k%cols) with value k.
    task automatic check_seq(input string tag, input rec_t q[$], input int n, input int cols);
        chk({tag, "_count"}, q.size(), n);
        for (int k = 0; k < q.size() && k < n; k++) begin
            chk($sformatf("%s_i%0d", tag, k), int'(q[k].i), k / cols);
            chk($sformatf("%s_j%0d", tag, k), int'(q[k].j), k % cols);
            chk($sformatf("%s_pix%0d", tag, k), int'(q[k].pix), k);
        end
    endtask

    initial begin
        //            cyc  tx    busy  done  rd    addr    pchk  pix      ip     jp
        tbl[0]  = '{  1, 1'b0, 1'b1, 1'b0, 1'b1, 17'd0,  1'b1, 12'd0,  9'd0, 8'd0};
        tbl[1]  = '{  2, 1'b0, 1'b1, 1'b0, 1'b0, 17'd0,  1'b1, 12'd0,  9'd0, 8'd0};
        tbl[2]  = '{  3, 1'b1, 1'b1, 1'b0, 1'b0, 17'd0,  1'b1, 12'd0,  9'd0, 8'd0};
        tbl[3]  = '{  4, 1'b0, 1'b1, 1'b0, 1'b0, 17'd0,  1'b0, 12'd0,  9'd0, 8'd0};
        tbl[4]  = '{  5, 1'b0, 1'b1, 1'b0, 1'b1, 17'd1,  1'b1, 12'd0,  9'd0, 8'd0};
        tbl[5]  = '{  7, 1'b1, 1'b1, 1'b0, 1'b0, 17'd1,  1'b1, 12'd1,  9'd0, 8'd1};
        tbl[6]  = '{ 19, 1'b1, 1'b1, 1'b0, 1'b0, 17'd4,  1'b1, 12'd4,  9'd0, 8'd4};
        tbl[7]  = '{ 21, 1'b0, 1'b1, 1'b0, 1'b1, 17'd5,  1'b1, 12'd4,  9'd0, 8'd4};
        tbl[8]  = '{ 23, 1'b1, 1'b1, 1'b0, 1'b0, 17'd5,  1'b1, 12'd5,  9'd1, 8'd0};
        tbl[9]  = '{ 55, 1'b1, 1'b1, 1'b0, 1'b0, 17'd13, 1'b1, 12'd13, 9'd2, 8'd3};
        tbl[10] = '{ 97, 1'b0, 1'b1, 1'b0, 1'b1, 17'd24, 1'b1, 12'd23, 9'd4, 8'd3};
        tbl[11] = '{ 99, 1'b1, 1'b1, 1'b0, 1'b0, 17'd24, 1'b1, 12'd24, 9'd4, 8'd4};
        tbl[12] = '{100, 1'b0, 1'b1, 1'b0, 1'b0, 17'd24, 1'b0, 12'd0,  9'd0, 8'd0};
        tbl[13] = '{101, 1'b0, 1'b1, 1'b1, 1'b0, 17'd24, 1'b1, 12'd24, 9'd4, 8'd4};
        tbl[14] = '{102, 1'b0, 1'b0, 1'b0, 1'b0, 17'd24, 1'b1, 12'd24, 9'd4, 8'd4};
        tbl[15] = '{103, 1'b0, 1'b0, 1'b0, 1'b0, 17'd24, 1'b0, 12'd0,  9'd0, 8'd0};

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", int'(tx), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd", int'(mem_rd_en), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_pix", int'(pixel), 0);
        chk("rst_ip", int'(i_p), 0);
        chk("rst_jp", int'(j_p), 0);
        chk("rst_busy2", int'(busy2), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Normal 5x5 frame, checked cycle by cycle against the table.
        q1.delete(); done1_cnt = 0;
        start_pulse(0);
        for (int c = 1; c <= 105; c++) begin
            @(negedge clk);
            foreach (tbl[k]) begin
                if (tbl[k].cyc == c) begin
                    chk($sformatf("norm_c%0d_tx", c), int'(tx), int'(tbl[k].tx));
                    chk($sformatf("norm_c%0d_busy", c), int'(busy), int'(tbl[k].busy));
                    chk($sformatf("norm_c%0d_done", c), int'(done), int'(tbl[k].done));
                    chk($sformatf("norm_c%0d_rd", c), int'(mem_rd_en), int'(tbl[k].rd));
                    chk($sformatf("norm_c%0d_addr", c), int'(mem_addr), int'(tbl[k].addr));
                    if (tbl[k].pchk) begin
                        chk($sformatf("norm_c%0d_pix", c), int'(pixel), int'(tbl[k].pix));
                        chk($sformatf("norm_c%0d_ip", c), int'(i_p), int'(tbl[k].ip));
                        chk($sformatf("norm_c%0d_jp", c), int'(j_p), int'(tbl[k].jp));
                    end
                end
            end
            tick();
        end
        check_seq("norm", q1, 25, 5);
        chk("norm_done_cnt", done1_cnt, 1);

        // Backpressure at pixel (2,3): out_ready low for cycles 53..62.
        q1.delete(); done1_cnt = 0;
        start_pulse(0);
        for (int c = 1; c <= 115; c++) begin
            out_ready = !(c >= 53 && c <= 62);
            @(negedge clk);
            if (c >= 55 && c <= 63) begin
                chk($sformatf("bp_c%0d_tx", c), int'(tx), 0);
                chk($sformatf("bp_c%0d_pix", c), int'(pixel), 13);
                chk($sformatf("bp_c%0d_ip", c), int'(i_p), 2);
                chk($sformatf("bp_c%0d_jp", c), int'(j_p), 3);
            end
            if (c == 64) chk("bp_tx_after_ready", int'(tx), 1);
            if (c == 110) chk("bp_done", int'(done), 1);
            tick();
        end
        out_ready = 1'b1;
        check_seq("bp", q1, 25, 5);
        chk("bp_done_cnt", done1_cnt, 1);

        // Abort during the STROBE of pixel (1,4).
        q1.delete(); done1_cnt = 0;
        start_pulse(0);
        for (int c = 1; c <= 50; c++) begin
            abort = (c == 39);
            @(negedge clk);
            if (c == 39) begin
                chk("abort_tx_completes", int'(tx), 1);
                chk("abort_ip", int'(i_p), 1);
                chk("abort_jp", int'(j_p), 4);
            end
            if (c >= 40) begin
                chk($sformatf("abort_c%0d_tx", c), int'(tx), 0);
                chk($sformatf("abort_c%0d_done", c), int'(done), 0);
            end
            if (c == 41) chk("abort_busy", int'(busy), 0);
            tick();
        end
        abort = 1'b0;
        check_seq("abort", q1, 10, 5);
        chk("abort_done_cnt", done1_cnt, 0);

        // Restart after abort; start re-asserted while busy and during FINISH.
        q1.delete(); done1_cnt = 0;
        start_pulse(0);
        for (int c = 1; c <= 106; c++) begin
            start = (c == 10 || c == 11 || c == 101);
            @(negedge clk);
            if (c == 1) chk("restart_addr", int'(mem_addr), 0);
            if (c == 2) chk("restart_pix_held", int'(pixel), 9);
            if (c == 3) begin
                chk("restart_pix", int'(pixel), 0);
                chk("restart_ip", int'(i_p), 0);
                chk("restart_jp", int'(j_p), 0);
            end
            if (c == 101) chk("sbusy_done", int'(done), 1);
            if (c == 102) chk("sbusy_idle102", int'(busy), 0);
            if (c == 103) chk("sbusy_idle103", int'(busy), 0);
            tick();
        end
        start = 1'b0;
        check_seq("sbusy", q1, 25, 5);
        chk("sbusy_done_cnt", done1_cnt, 1);

        // Asynchronous reset in the CAPTURE cycle of pixel (1,1).
        q1.delete(); done1_cnt = 0;
        start_pulse(0);
        for (int c = 1; c < 26; c++) tick();
        @(negedge clk);
        chk("arst_pre_pix", int'(pixel), 5);
        chk("arst_pre_ip", int'(i_p), 1);
        chk("arst_pre_addr", int'(mem_addr), 6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pix", int'(pixel), 0);
        chk("arst_ip", int'(i_p), 0);
        chk("arst_jp", int'(j_p), 0);
        chk("arst_addr", int'(mem_addr), 0);
        chk("arst_rd", int'(mem_rd_en), 0);
        chk("arst_tx", int'(tx), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("arst_after%0d_tx", c), int'(tx), 0);
            chk($sformatf("arst_after%0d_busy", c), int'(busy), 0);
            tick();
        end
        check_seq("arst", q1, 6, 5);

        // 3x7 instance.
        q2.delete(); done2_cnt = 0;
        start_pulse(1);
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (c == 81) begin
                chk("g37_rd", int'(mem_rd_en2), 1);
                chk("g37_addr81", int'(mem_addr2), 20);
            end
            if (c == 83) begin
                chk("g37_last_ip", int'(i_p2), 2);
                chk("g37_last_jp", int'(j_p2), 6);
            end
            if (c == 84) chk("g37_done84", int'(done2), 0);
            if (c == 85) begin
                chk("g37_done85", int'(done2), 1);
                chk("g37_addr85", int'(mem_addr2), 20);
            end
            if (c == 86) begin
                chk("g37_busy86", int'(busy2), 0);
                chk("g37_addr86", int'(mem_addr2), 20);
            end
            tick();
        end
        check_seq("g37", q2, 21, 7);
        chk("g37_done_cnt", done2_cnt, 1);
        chk("g37_dut1_quiet", q1.size(), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
